// File: rtl/dcache_pkg.sv
// dcache shared definitions: FSM state encoding,
// block geometry and address-split helpers.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2,
      UPDATE    = 2'd3
   } state_t;

   localparam int BLOCK_BYTES = 4;
   localparam int OFFSET_W    = 2;

   function automatic int index_w(input int nb);
      return $clog2(nb);
   endfunction

   function automatic int tag_w(input int aw, input int nb);
      return aw - $clog2(nb) - OFFSET_W;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache line storage: valid/dirty/tag/data per line,
// one combinational read port, byte-write and block-fill ports.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int INDEX_W = 3,
   parameter int TAG_W   = 3
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [INDEX_W-1:0] i_idx,
   input  logic               i_wr_byte,
   input  logic [1:0]         i_wr_off,
   input  logic [7:0]         i_wr_data,
   input  logic               i_fill,
   input  logic [TAG_W-1:0]   i_fill_tag,
   input  logic [31:0]        i_fill_data,
   output logic               o_valid,
   output logic               o_dirty,
   output logic [TAG_W-1:0]   o_tag,
   output logic [31:0]        o_data
);

   localparam int NB = 1 << INDEX_W;

   logic [NB-1:0]    r_valid;
   logic [NB-1:0]    r_dirty;
   logic [TAG_W-1:0] r_tag  [NB];
   logic [31:0]      r_data [NB];

   assign o_valid = r_valid[i_idx];
   assign o_dirty = r_dirty[i_idx];
   assign o_tag   = r_tag[i_idx];
   assign o_data  = r_data[i_idx];

   // Line status: cleared on reset, set clean on fill, dirty on store
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_fill) begin
         r_valid[i_idx] <= 1'b1;
         r_dirty[i_idx] <= 1'b0;
      end else if (i_wr_byte) begin
         r_dirty[i_idx] <= 1'b1;
      end
   end

   // Tag/data payload: whole-block refill or single-byte store
   always_ff @(posedge CLK) begin
      if (i_fill) begin
         r_tag[i_idx]  <= i_fill_tag;
         r_data[i_idx] <= i_fill_data;
      end else if (i_wr_byte) begin
         r_data[i_idx][{i_wr_off, 3'b000} +: 8] <= i_wr_data;
      end
   end

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped write-back write-allocate data cache
// between the byte-wide CPU port and 32-bit block memory.
module dcache
   import dcache_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int NUM_BLOCKS = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              READ,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] ADDRESS,
   input  logic [7:0]        WRITEDATA,
   output logic [7:0]        READDATA,
   output logic              BUSYWAIT,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-3:0] mem_address,
   output logic [31:0]       mem_writedata,
   input  logic [31:0]       mem_readdata,
   input  logic              mem_busywait
);

   localparam int INDEX_W = index_w(NUM_BLOCKS);
   localparam int TAG_W   = tag_w(ADDR_W, NUM_BLOCKS);

   state_t r_state;
   state_t w_next;

   logic [TAG_W-1:0]   w_tag;
   logic [INDEX_W-1:0] w_idx;
   logic [1:0]         w_off;
   logic               w_req;
   logic               w_valid;
   logic               w_dirty;
   logic [TAG_W-1:0]   w_line_tag;
   logic [31:0]        w_data;
   logic               w_hit;
   logic               w_wr_byte;
   logic               w_fill;

   assign w_tag = ADDRESS[ADDR_W-1 -: TAG_W];
   assign w_idx = ADDRESS[OFFSET_W +: INDEX_W];
   assign w_off = ADDRESS[1:0];
   assign w_req = READ | WRITE;

   assign w_hit = w_valid & (w_line_tag == w_tag);

   // A store wins when READ and WRITE are both high
   assign w_wr_byte = (r_state == IDLE) & WRITE & w_hit;
   assign w_fill    = (r_state == UPDATE);

   assign READDATA = w_hit ? w_data[{w_off, 3'b000} +: 8] : 8'h00;
   assign BUSYWAIT = w_req & ~((r_state == IDLE) & w_hit);

   dcache_array #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_array (
      .CLK         (CLK),
      .RESET       (RESET),
      .i_idx       (w_idx),
      .i_wr_byte   (w_wr_byte),
      .i_wr_off    (w_off),
      .i_wr_data   (WRITEDATA),
      .i_fill      (w_fill),
      .i_fill_tag  (w_tag),
      .i_fill_data (mem_readdata),
      .o_valid     (w_valid),
      .o_dirty     (w_dirty),
      .o_tag       (w_line_tag),
      .o_data      (w_data)
   );

   // State register; reset aborts any miss in flight
   always_ff @(posedge CLK) begin
      if (RESET) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next state: miss handling with optional writeback first
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_req & ~w_hit) begin
               if (w_valid & w_dirty) w_next = MEM_WRITE;
               else                   w_next = MEM_READ;
            end
         end
         MEM_WRITE: begin
            if (~mem_busywait) w_next = MEM_READ;
         end
         MEM_READ: begin
            if (~mem_busywait) w_next = UPDATE;
         end
         UPDATE: begin
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Memory-side outputs decoded from state only
   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = {w_tag, w_idx};
      mem_writedata = w_data;
      unique case (r_state)
         MEM_WRITE: begin
            mem_write   = 1'b1;
            mem_address = {w_line_tag, w_idx};
         end
         MEM_READ: begin
            mem_read = 1'b1;
         end
         default: begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed plus random accesses checked against
// a byte-level shadow memory and line-occupancy model.
module tb_dcache;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        READ = 1'b0;
   logic        WRITE = 1'b0;
   logic [7:0]  ADDRESS = 8'h00;
   logic [7:0]  WRITEDATA = 8'h00;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;

   int tests = 0;
   int fails = 0;
   int lat = 5;

   logic [31:0] memarr [64];
   bit          seeded;
   int          cnt;

   logic [7:0]  shadow [256];
   bit          m_valid [8];
   bit          m_dirty [8];
   logic [2:0]  m_tag [8];

   always #5 CLK = ~CLK;

   dcache dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .READ          (READ),
      .WRITE         (WRITE),
      .ADDRESS       (ADDRESS),
      .WRITEDATA     (WRITEDATA),
      .READDATA      (READDATA),
      .BUSYWAIT      (BUSYWAIT),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
   );

   // Block memory: busy for lat cycles after a strobe rises
   assign mem_busywait = (mem_read | mem_write) && (cnt != lat);
   assign mem_readdata = memarr[mem_address];

   always @(posedge CLK) begin
      if (RESET) begin
         cnt <= 0;
         if (!seeded) begin
            for (int i = 0; i < 64; i++) memarr[i] <= $urandom;
            memarr[0] <= 32'hDDCCBBAA;
            seeded <= 1'b1;
         end
      end else if (mem_read | mem_write) begin
         if (cnt == lat) begin
            cnt <= 0;
            if (mem_write) memarr[mem_address] <= mem_writedata;
         end else begin
            cnt <= cnt + 1;
         end
      end else begin
         cnt <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sync_model();
      for (int i = 0; i < 256; i++) shadow[i] = memarr[i >> 2][(i % 4) * 8 +: 8];
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
      end
   endtask

   function automatic logic [31:0] blk(input logic [5:0] ba);
      return {shadow[{ba, 2'd3}], shadow[{ba, 2'd2}],
              shadow[{ba, 2'd1}], shadow[{ba, 2'd0}]};
   endfunction

   // One CPU access; expectations come from the shadow/line model
   task automatic access(input bit rd, input bit wr,
                         input logic [7:0] a, input logic [7:0] d);
      int idx, n, exp_cyc;
      bit hit, dirty_ev;
      logic [2:0] tg;
      logic [5:0] ev_addr;
      logic [31:0] ev_data;
      idx = int'(a[4:2]);
      tg = a[7:5];
      hit = m_valid[idx] && (m_tag[idx] == tg);
      dirty_ev = !hit && m_valid[idx] && m_dirty[idx];
      ev_addr = {m_tag[idx], a[4:2]};
      ev_data = blk(ev_addr);
      READ = rd;
      WRITE = wr;
      ADDRESS = a;
      WRITEDATA = d;
      #1;
      chk("busy_on_request", 32'(BUSYWAIT), 32'(!hit));
      if (hit) begin
         chk("hit_no_strobe", 32'(mem_read | mem_write), 0);
      end else begin
         exp_cyc = dirty_ev ? 2 * lat + 4 : lat + 3;
         n = 0;
         while (BUSYWAIT && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
            if (n == 1 && dirty_ev) begin
               chk("wb_strobe", 32'({mem_write, mem_read}), 32'b10);
               chk("wb_addr", 32'(mem_address), 32'(ev_addr));
               chk("wb_data", mem_writedata, ev_data);
            end
            if ((n == 1 && !dirty_ev) || (dirty_ev && n == lat + 2)) begin
               chk("fetch_strobe", 32'({mem_write, mem_read}), 32'b01);
               chk("fetch_addr", 32'(mem_address), 32'({tg, a[4:2]}));
            end
         end
         chk("miss_latency", n, exp_cyc);
         m_valid[idx] = 1;
         m_tag[idx] = tg;
         m_dirty[idx] = 0;
      end
      if (!wr) chk("readdata", 32'(READDATA), 32'(shadow[a]));
      @(posedge CLK);
      #1;
      if (wr) begin
         shadow[a] = d;
         m_dirty[idx] = 1;
      end
      READ = 1'b0;
      WRITE = 1'b0;
   endtask

   initial begin
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      chk("reset_busy", 32'(BUSYWAIT), 0);
      chk("reset_strobes", 32'({mem_read, mem_write}), 0);
      sync_model();

      lat = 5;
      access(1, 0, 8'h00, 8'h00);
      access(1, 0, 8'h03, 8'h00);
      chk("hit_byte3", 32'(shadow[8'h03]), 32'hDD);
      access(0, 1, 8'h01, 8'h55);
      access(1, 0, 8'h01, 8'h00);
      lat = 2;
      access(1, 0, 8'h20, 8'h00);
      chk("wb_to_mem", memarr[0], 32'hDDCC55AA);

      READ = 1'b1;
      ADDRESS = 8'h44;
      @(posedge CLK);
      #1;
      chk("pre_reset_fetch", 32'(mem_read), 1);
      RESET = 1'b1;
      READ = 1'b0;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      chk("abort_strobe", 32'(mem_read | mem_write), 0);
      chk("abort_busy", 32'(BUSYWAIT), 0);
      sync_model();
      access(1, 0, 8'h03, 8'h00);

      access(1, 1, 8'h02, 8'h77);
      access(1, 0, 8'h02, 8'h00);
      chk("rw_as_store", 32'(shadow[8'h02]), 32'h77);
      access(1, 0, 8'h22, 8'h00);
      chk("rw_wb_mem", memarr[0], {shadow[3], 8'h77, shadow[1], shadow[0]});

      for (int k = 0; k < 300; k++) begin
         logic [7:0] ra;
         int op;
         lat = $urandom_range(1, 4);
         ra = 8'($urandom);
         if (k % 2 == 0) ra[7] = 1'b0;
         op = $urandom_range(0, 9);
         access(op < 5, op >= 5, ra, 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dcache.md
Name: dcache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the 8-bit CPU's data port and the 32-bit-block data memory.
- Presents the CPU with the byte interface it already drives (READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT).
- Services hits in one cycle; fetches and evicts whole 4-byte blocks over the memory-side handshake on misses.

Parameters:
- ADDR_W, 8, CPU byte-address width.
- NUM_BLOCKS, 8, cache lines, power of 2; INDEX_W = log2(NUM_BLOCKS); TAG_W = ADDR_W - INDEX_W - 2.

Ports:
- CLK  in  1  clock, all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- READ  in  1  CPU load request
- WRITE  in  1  CPU store request
- ADDRESS  in  ADDR_W  CPU byte address {tag, index, offset[1:0]}
- WRITEDATA  in  8  CPU store byte
- READDATA  out  8  load byte to CPU
- BUSYWAIT  out  1  CPU stall
- mem_read  out  1  block fetch strobe
- mem_write  out  1  block writeback strobe
- mem_address  out  ADDR_W-2  block address {tag, index}
- mem_writedata  out  32  evicted block, byte0 in [7:0]
- mem_readdata  in  32  fetched block, byte0 in [7:0]
- mem_busywait  in  1  memory busy; rises combinationally with strobe, falls when transfer done

Behaviour:
- Reset (posedge with RESET=1): all valid/dirty bits 0, state IDLE, mem_read=mem_write=0, BUSYWAIT=0. Tags/data need no reset.
- RESET mid-miss: abort at that edge; strobes drop; dirty data discarded (documented loss, not an error).
- Storage per line: valid, dirty, tag[TAG_W-1:0], data[31:0].
- hit = valid[index] & (tag[index] == ADDRESS tag).
- READDATA: combinational byte data[index][8*offset +: 8] when hit, else 8'h00.
- BUSYWAIT: combinational = (READ|WRITE) & ~(state==IDLE & hit). 0 when no request. Asserted in the same cycle as a missing request.
- Simultaneous READ and WRITE: treated as WRITE.
- Request changes while not IDLE: undefined; the CPU holds READ/WRITE/ADDRESS until BUSYWAIT falls.
- States: IDLE, MEM_READ, MEM_WRITE, UPDATE.
- IDLE:
  - Read hit: no state change, zero-latency data.
  - Write hit: at posedge, byte written into data[index], dirty[index]=1.
  - Miss, line clean or invalid: -> MEM_READ.
  - Miss, line valid and dirty: -> MEM_WRITE.
- MEM_WRITE:
  - mem_write=1, mem_address={tag[index], index}, mem_writedata=data[index].
  - Stays a minimum of 1 cycle. At the first posedge in state with mem_busywait=0 -> MEM_READ.
- MEM_READ:
  - mem_read=1, mem_address={ADDRESS tag, index}.
  - Stays a minimum of 1 cycle. At the first posedge in state with mem_busywait=0 -> UPDATE.
- UPDATE (1 cycle, no strobes):
  - At its posedge: data[index]=mem_readdata, tag updated, valid=1, dirty=0.
  - -> IDLE. The request then hits in the following cycle: read data returns, or the write completes and sets dirty.
- Strobes are registered/Moore outputs of state; never both 1.
- Miss latency (clean) = 1 + memory cycles + 1 UPDATE + hit cycle. Dirty miss adds the writeback duration.
- Index wrap: addresses differing only in tag map to the same line and evict each other. No associativity.

Decomposition:
- Shared package dcache_pkg: state encodings (IDLE=2'd0, MEM_READ=2'd1, MEM_WRITE=2'd2, UPDATE=2'd3), BLOCK_BYTES=4, OFFSET_W=2, derived INDEX_W/TAG_W helpers.
- One natural sub-module, dcache_array: valid/dirty/tag/data storage with read port (index) and write ports for byte write and block fill.
- The FSM and hit logic stay in dcache.

Test Plan:
1. Reset then READ ADDRESS=8'h00 -> BUSYWAIT=1 same cycle, mem_read=1 mem_address=6'h00. Memory returns 32'hDDCCBBAA after 5 cycles -> UPDATE, then READDATA=8'hAA, BUSYWAIT=0.
2. After 1, READ 8'h03 -> hit, BUSYWAIT stays 0, READDATA=8'hDD same cycle, no strobes.
3. WRITE 8'h01 data 8'h55 (hit) -> no stall, dirty[0]=1. Then READ 8'h01 -> 8'h55.
4. After 3, READ 8'h20 (same index 0, tag 1) -> mem_write=1, mem_address=6'h00, mem_writedata=32'hDDCC55AA. Then mem_read with mem_address=6'h08; line refilled, dirty=0.
5. RESET asserted during MEM_READ -> next cycle state IDLE, mem_read=0, BUSYWAIT=0 with no request. READ 8'h03 then misses (valid cleared).
6. READ=WRITE=1 on a hit line, ADDRESS 8'h02, WRITEDATA 8'h77 -> treated as store; byte 2 becomes 8'h77, dirty=1.
